// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared state encoding and width helpers for the maxnet engine
package maxnet_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sum_w(input int w, input int n);
    return w + $clog2(n);
  endfunction

  function automatic int cnt_w(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/maxnet_cell.sv
// rtl/maxnet_cell.sv - one channel's lateral-inhibition update
module maxnet_cell #(
  parameter int W         = 8,
  parameter int SUM_W     = 10,
  parameter int EPS_SHIFT = 2
) (
  input  logic [W-1:0]     a,
  input  logic [SUM_W-1:0] s,
  output logic [W-1:0]     a_next,
  output logic             nz
);

  logic [SUM_W-1:0]   others;
  logic [SUM_W-1:0]   inhib;
  logic signed [SUM_W:0] t;

  // s already contains a, so the inhibition comes from the other channels only
  assign others = s - SUM_W'(a);
  assign inhib  = others >> EPS_SHIFT;
  assign t      = $signed({1'b0, SUM_W'(a)}) - $signed({1'b0, inhib});

  assign a_next = t[SUM_W] ? '0 : t[W-1:0];
  assign nz     = |a;

endmodule

// File: rtl/maxnet_param.sv
// rtl/maxnet_param.sv - parametrised winner-take-all engine with start/done handshake
module maxnet_param
  import maxnet_pkg::*;
#(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N*W-1:0]                x_in,
  output logic                          busy,
  output logic                          done,
  output logic [idx_w(N)-1:0]           winner_idx,
  output logic [W-1:0]                  result,
  output logic                          tie,
  output logic [cnt_w(MAX_ITER)-1:0]    iter_count
);

  localparam int IDX_W = idx_w(N);
  localparam int SUM_W = sum_w(W, N);
  localparam int CNT_W = cnt_w(MAX_ITER);
  localparam int NZ_W  = $clog2(N + 1);

  state_t state_q, state_d;

  logic [N-1:0][W-1:0] a, o, a_next;
  logic [N-1:0]        nz;
  logic [SUM_W-1:0]    sum;
  logic [NZ_W-1:0]     nz_cnt;
  logic [IDX_W-1:0]    pe_idx;
  logic                load, step, fin;

  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) sum = sum + SUM_W'(a[i]);
  end

  for (genvar g = 0; g < N; g++) begin : g_cell
    maxnet_cell #(.W(W), .SUM_W(SUM_W), .EPS_SHIFT(EPS_SHIFT)) u_cell (
      .a      (a[g]),
      .s      (sum),
      .a_next (a_next[g]),
      .nz     (nz[g])
    );
  end

  // survivor count and lowest-index survivor
  always_comb begin
    nz_cnt = '0;
    pe_idx = '0;
    for (int i = 0; i < N; i++) nz_cnt = nz_cnt + NZ_W'(nz[i]);
    for (int i = N - 1; i >= 0; i--) if (nz[i]) pe_idx = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        if (nz_cnt <= NZ_W'(1) || iter_count == CNT_W'(MAX_ITER)) begin
          fin     = 1'b1;
          state_d = DONE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a          <= '0;
      o          <= '0;
      iter_count <= '0;
      winner_idx <= '0;
      result     <= '0;
      tie        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        a          <= x_in;
        o          <= x_in;
        iter_count <= '0;
        tie        <= 1'b0;
      end
      if (step) begin
        a          <= a_next;
        iter_count <= iter_count + CNT_W'(1);
      end
      if (fin) begin
        // no survivors reports channel 0 with a zero result
        if (nz_cnt == '0) begin
          winner_idx <= '0;
          result     <= '0;
          tie        <= 1'b1;
        end else begin
          winner_idx <= pe_idx;
          result     <= o[pe_idx];
          tie        <= (nz_cnt != NZ_W'(1));
        end
      end
    end
  end

  assign busy = (state_q == ITER);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_maxnet_param.sv
// tb/tb_maxnet_param.sv - scoreboard bench for maxnet_param against a behavioural model
module tb_maxnet_param;

  localparam int N = 4;
  localparam int W = 8;
  localparam int MAX_ITER = 64;

  typedef struct {
    int idx;
    int res;
    int tie;
    int it;
    int lat;
    int lcyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N*W-1:0] x_in;
  logic         busy, done, tie;
  logic [1:0]   winner_idx;
  logic [W-1:0] result;
  logic [6:0]   iter_count;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  bit   done_prev = 1'b0;
  exp_t q[$];

  maxnet_param #(.N(N), .W(W), .EPS_SHIFT(2), .MAX_ITER(MAX_ITER)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x_in       (x_in),
    .busy       (busy),
    .done       (done),
    .winner_idx (winner_idx),
    .result     (result),
    .tie        (tie),
    .iter_count (iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Winner-take-all reference: iterate the inhibition rule on plain integers
  function automatic exp_t model(input int x[4]);
    exp_t e;
    int a[4];
    int na[4];
    int s, nzc, it;
    bit run;
    a = x;
    it = 0;
    run = 1'b1;
    nzc = 0;
    while (run) begin
      nzc = 0;
      s = 0;
      foreach (a[i]) begin
        if (a[i] != 0) nzc++;
        s += a[i];
      end
      if (nzc <= 1 || it == MAX_ITER) begin
        run = 1'b0;
      end else begin
        foreach (a[i]) begin
          na[i] = a[i] - ((s - a[i]) / 4);
          if (na[i] < 0) na[i] = 0;
        end
        a = na;
        it++;
      end
    end
    e.it = it;
    e.lat = it + 2;
    e.lcyc = 0;
    if (nzc == 0) begin
      e.idx = 0;
      e.res = 0;
      e.tie = 1;
    end else begin
      e.idx = -1;
      for (int i = 3; i >= 0; i--) if (a[i] != 0) e.idx = i;
      e.res = x[e.idx];
      e.tie = (nzc != 1) ? 1 : 0;
    end
    return e;
  endfunction

  function automatic logic [N*W-1:0] pack(input int x[4]);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = x[i][W-1:0];
    return v;
  endfunction

  task automatic issue(input int v0, input int v1, input int v2, input int v3);
    int x[4];
    exp_t e;
    x = '{v0, v1, v2, v3};
    @(negedge clk);
    start = 1'b1;
    x_in = pack(x);
    @(posedge clk);
    #1;
    e = model(x);
    e.lcyc = cyc;
    q.push_back(e);
    start = 1'b0;
    x_in = $urandom;
  endtask

  task automatic wait_done();
    for (int c = 0; c < 200 && q.size() > 0; c++) @(negedge clk);
    if (q.size() > 0) begin
      check("done_timeout", 0, 1);
      q.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done && !done_prev) begin
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = q.pop_front();
        check("winner_idx", int'(winner_idx), e.idx);
        check("result", int'(result), e.res);
        check("tie", int'(tie), e.tie);
        check("iter_count", int'(iter_count), e.it);
        check("latency", cyc - e.lcyc + 1, e.lat);
      end
    end
    done_prev = done;
  end

  initial begin
    int x[4];
    rst = 1'b1;
    start = 1'b0;
    x_in = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_idx", int'(winner_idx), 0);
    check("rst_result", int'(result), 0);
    check("rst_tie", int'(tie), 0);
    check("rst_iter", int'(iter_count), 0);
    rst = 1'b0;

    issue(10, 20, 30, 40); wait_done();
    issue(0, 0, 7, 0);     wait_done();
    issue(50, 50, 0, 0);   wait_done();
    issue(0, 0, 0, 0);     wait_done();

    // start during ITER must be ignored
    issue(10, 20, 30, 40);
    @(negedge clk);
    start = 1'b1;
    x = '{200, 1, 1, 1};
    x_in = pack(x);
    @(negedge clk);
    check("busy_hold", int'(busy), 1);
    start = 1'b0;
    wait_done();

    // restart straight out of DONE
    check("done_before_restart", int'(done), 1);
    issue(5, 0, 9, 0);
    check("done_drop", int'(done), 0);
    wait_done();

    // asynchronous reset mid-ITER
    @(negedge clk);
    start = 1'b1;
    x = '{10, 20, 30, 40};
    x_in = pack(x);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(done), 0);
    check("arst_idx", int'(winner_idx), 0);
    check("arst_result", int'(result), 0);
    check("arst_tie", int'(tie), 0);
    check("arst_iter", int'(iter_count), 0);
    @(negedge clk);
    rst = 1'b0;
    issue(0, 0, 7, 0); wait_done();

    for (int k = 0; k < 24; k++) begin
      int v[4];
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: v[i] = 0;
          1: v[i] = $urandom_range(1, 15);
          default: v[i] = $urandom_range(0, 255);
        endcase
      end
      issue(v[0], v[1], v[2], v[3]);
      wait_done();
    end

    check("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
